rom_burst_reader: RTL

Upstream sequencer for the 16x8 enable-gated ROM (rom16_8 / test32). It accepts a burst request (start address, length) and drives the ROM's i_en/i_addr pins itself. It captures the ROM's combinational o_data into a registered valid/ready output stream. It also flags the last beat and pulses done at the end of each burst, replacing the hand-written address stepping done in benches today.

---
 rtl/rom_burst_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rom_burst_reader.sv
// -----------------------------------------------------------------------------
// rom_burst_reader
//
// Burst sequencer for a small enable-gated ROM with combinational read data.
// A burst request (start address, length) is accepted while idle. The block
// then drives the ROM enable/address pins itself, steps the address once per
// captured beat (wrapping at the top of the ROM), and presents each ROM word on
// a registered valid/ready stream. The final beat of a burst is flagged with
// o_last, and o_done pulses for one cycle once that beat has been accepted.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       burst request, sampled on the rising edge while idle
//   i_start_addr  first ROM address of the burst
//   i_len         beats in the burst (0 ignored, values above depth clamped)
//   o_busy        high from the cycle after an accepted start until done
//   o_rom_en      ROM enable, high only while reading
//   o_rom_addr    ROM address
//   i_rom_data    ROM read data, combinational from o_rom_addr
//   o_data        registered read data
//   o_valid       o_data holds a beat not yet accepted
//   i_ready       downstream accepts the beat when o_valid && i_ready
//   o_last        marks the final beat of the burst (qualified by o_valid)
//   o_done        one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module rom_burst_reader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    output logic              o_rom_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Longest legal burst: one pass over the whole ROM.
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;     // next ROM address to read
    logic [LEN_W-1:0]  rem_q;      // beats still to be captured from the ROM
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              last_q;
    logic              done_q;
    logic              busy_q;
    logic              rom_en_q;

    logic [LEN_W-1:0]  len_clamped;
    logic              accept;
    logic              capture;

    // Over-long requests read the ROM exactly once rather than re-reading
    // wrapped addresses.
    assign len_clamped = (i_len > MAX_LEN) ? MAX_LEN : i_len;

    // Beat handed to the downstream at the coming edge.
    assign accept = valid_q && i_ready;

    // The output register can take a new ROM word when it is empty or being
    // drained at this edge, which gives one beat per cycle under full ready.
    assign capture = (state_q == ST_READ) && (rem_q != '0) && (!valid_q || i_ready);

    // NOTE: every register below is written with non-blocking assignments so
    // that all state updates see the pre-edge values of the other registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rom_en_q <= 1'b0;
        end else begin
            // o_done is a pulse; only the READ->DONE transition raises it.
            done_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    // Zero-length requests are dropped without any visible
                    // effect; the address output keeps its previous value.
                    if (i_start && (i_len != '0)) begin
                        addr_q   <= i_start_addr;
                        rem_q    <= len_clamped;
                        busy_q   <= 1'b1;
                        rom_en_q <= 1'b1;
                        state_q  <= ST_READ;
                    end
                end

                ST_READ: begin
                    if (accept && last_q) begin
                        // Final beat leaves the block; nothing remains to read.
                        valid_q  <= 1'b0;
                        last_q   <= 1'b0;
                        rom_en_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (capture) begin
                        data_q  <= i_rom_data;
                        valid_q <= 1'b1;
                        last_q  <= (rem_q == LEN_W'(1));
                        addr_q  <= addr_q + ADDR_W'(1);  // wraps at ROM top
                        rem_q   <= rem_q - LEN_W'(1);
                    end else if (accept) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                    // Otherwise stalled: data, last, address and count hold.
                end

                ST_DONE: begin
                    // Starts seen here are dropped, not queued.
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_rom_en   = rom_en_q;
    assign o_rom_addr = addr_q;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_last     = last_q;
    assign o_done     = done_q;

endmodule
